// File: rtl/fpu_pkg.sv
// Shared FPU constants and types for the FMADD add/normalise path.
// Field widths are expressed as MSB indices to match the packed FP word layout.
package fpu_pkg;

  localparam int STD   = 31;
  localparam int MAN   = 22;
  localparam int EXP   = 7;
  localparam int SUM_W = MAN + 6;
  localparam int LZ_W  = $clog2(MAN + 6);

  typedef enum logic [2:0] {
    FRM_RNE = 3'b000,
    FRM_RTZ = 3'b001,
    FRM_RDN = 3'b010,
    FRM_RUP = 3'b011,
    FRM_RMM = 3'b100
  } frm_e;

  typedef struct packed {
    logic guard;
    logic round;
    logic sticky;
  } grs_t;

  typedef struct packed {
    logic [MAN+1:0] mant;
    logic [EXP+1:0] exp;
    grs_t           grs;
    logic           zero;
  } norm_t;

endpackage

// File: rtl/fmadd_add_normalize_pipe_if.sv
// Handshake and data bundle between the significand adder, the normaliser and
// the rounding block. master = upstream/downstream environment, slave = normaliser.
interface fmadd_add_normalize_pipe_if;
  import fpu_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [MAN+5:0] in_sum;
  logic           in_sticky;
  logic [EXP+1:0] in_exp;
  logic           in_sign;
  logic [2:0]     in_frm;
  logic           in_uf_opa;
  logic           in_nx_mul;

  logic           out_valid;
  logic           out_ready;
  logic [MAN+1:0] out_mant;
  logic [EXP+1:0] out_exp;
  logic           out_guard;
  logic           out_round;
  logic           out_sticky;
  logic           out_sign;
  logic [2:0]     out_frm;
  logic           out_uf_opa;
  logic           out_nx_mul;
  logic           out_zero;

  modport master (
    output in_valid, in_sum, in_sticky, in_exp, in_sign, in_frm, in_uf_opa, in_nx_mul,
    input  in_ready,
    output out_ready,
    input  out_valid, out_mant, out_exp, out_guard, out_round, out_sticky,
           out_sign, out_frm, out_uf_opa, out_nx_mul, out_zero
  );

  modport slave (
    input  in_valid, in_sum, in_sticky, in_exp, in_sign, in_frm, in_uf_opa, in_nx_mul,
    output in_ready,
    input  out_ready,
    output out_valid, out_mant, out_exp, out_guard, out_round, out_sticky,
           out_sign, out_frm, out_uf_opa, out_nx_mul, out_zero
  );

endinterface

// File: rtl/fmadd_add_normalize_pipe_lzc.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero input.
module fmadd_lzc #(
  parameter int WIDTH = 27,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CNT_W-1:0] o_cnt
);

  // Scanning upward lets the highest set bit have the final say.
  always_comb begin
    o_cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fmadd_add_normalize_pipe.sv
// Two-stage normaliser: stage 1 registers the adder sum and its leading-zero
// count, stage 2 shifts, adjusts the exponent and regenerates guard/round/sticky.
module fmadd_add_normalize_pipe
  import fpu_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  fmadd_add_normalize_pipe_if.slave     bus
);

  logic           r_vld_p1, r_vld_p2;
  logic           w_rdy_p1, w_rdy_p2;
  logic [LZ_W-1:0] w_lz_p0;

  logic [MAN+5:0] r_sum_p1;
  logic           r_sticky_p1;
  logic [EXP+1:0] r_exp_p1;
  logic [LZ_W-1:0] r_lz_p1;
  logic           r_sign_p1, r_uf_p1, r_nx_p1;
  logic [2:0]     r_frm_p1;

  norm_t          w_norm_p1;
  norm_t          r_norm_p2;
  logic           r_sign_p2, r_uf_p2, r_nx_p2;
  logic [2:0]     r_frm_p2;

  // Subnormal results clamp the shift so the exponent never drops below 1.
  function automatic norm_t normalize(input logic [MAN+5:0]  sum,
                                      input logic            stk,
                                      input logic [EXP+1:0]  e,
                                      input logic [LZ_W-1:0] lz);
    norm_t          n;
    logic [EXP+1:0] lim;
    logic [EXP+1:0] sh;
    logic [MAN+4:0] t;
    n   = '0;
    lim = e - (EXP+2)'(1);
    sh  = '0;
    t   = '0;
    if (sum[MAN+5]) begin
      n.mant       = sum[MAN+5:4];
      n.grs.guard  = sum[3];
      n.grs.round  = sum[2];
      n.grs.sticky = sum[1] | sum[0] | stk;
      n.exp        = e + (EXP+2)'(1);
    end else if (sum == '0 && !stk) begin
      n.zero = 1'b1;
    end else begin
      if (e == '0)                     sh = '0;
      else if ((EXP+2)'(lz) < lim)     sh = (EXP+2)'(lz);
      else                             sh = lim;
      t            = sum[MAN+4:0] << sh;
      n.mant       = t[MAN+4:3];
      n.grs.guard  = t[2];
      n.grs.round  = t[1];
      n.grs.sticky = t[0] | stk;
      n.exp        = e - sh;
    end
    return n;
  endfunction

  assign w_rdy_p2     = ~r_vld_p2 | bus.out_ready;
  assign w_rdy_p1     = ~r_vld_p1 | w_rdy_p2;
  assign bus.in_ready = w_rdy_p1;

  fmadd_lzc #(.WIDTH(MAN + 5), .CNT_W(LZ_W)) u_lzc (
    .i_data (bus.in_sum[MAN+4:0]),
    .o_cnt  (w_lz_p0)
  );

  // ---- stage 0 -> 1: capture sum, exponent and leading-zero count ----
  always_ff @(posedge clk) begin
    if (rst || flush)  r_vld_p1 <= 1'b0;
    else if (w_rdy_p1) r_vld_p1 <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid && w_rdy_p1) begin
      r_sum_p1    <= bus.in_sum;
      r_sticky_p1 <= bus.in_sticky;
      r_exp_p1    <= bus.in_exp;
      r_lz_p1     <= w_lz_p0;
      r_sign_p1   <= bus.in_sign;
      r_frm_p1    <= bus.in_frm;
      r_uf_p1     <= bus.in_uf_opa;
      r_nx_p1     <= bus.in_nx_mul;
    end
  end

  // ---- stage 1 -> 2: shift, exponent adjust, GRS regeneration ----
  assign w_norm_p1 = normalize(r_sum_p1, r_sticky_p1, r_exp_p1, r_lz_p1);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_vld_p2  <= 1'b0;
      r_norm_p2 <= '0;
      r_sign_p2 <= 1'b0;
      r_frm_p2  <= '0;
      r_uf_p2   <= 1'b0;
      r_nx_p2   <= 1'b0;
    end else if (w_rdy_p2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_norm_p2 <= w_norm_p1;
        r_sign_p2 <= r_sign_p1;
        r_frm_p2  <= r_frm_p1;
        r_uf_p2   <= r_uf_p1;
        r_nx_p2   <= r_nx_p1;
      end
    end
  end

  assign bus.out_valid  = r_vld_p2;
  assign bus.out_mant   = r_norm_p2.mant;
  assign bus.out_exp    = r_norm_p2.exp;
  assign bus.out_guard  = r_norm_p2.grs.guard;
  assign bus.out_round  = r_norm_p2.grs.round;
  assign bus.out_sticky = r_norm_p2.grs.sticky;
  assign bus.out_zero   = r_norm_p2.zero;
  assign bus.out_sign   = r_sign_p2;
  assign bus.out_frm    = r_frm_p2;
  assign bus.out_uf_opa = r_uf_p2;
  assign bus.out_nx_mul = r_nx_p2;

endmodule

// File: tb/tb_fmadd_add_normalize_pipe.sv
// Scoreboard bench for the FMADD add/normalise pipe: directed spec cases,
// backpressure, flush/reset mid-stall and randomized traffic against a reference model.
module tb_fmadd_add_normalize_pipe;
  import fpu_pkg::*;

  typedef struct packed {
    logic [27:0] sum;
    logic        sticky;
    logic [8:0]  exp;
    logic        sign;
    logic [2:0]  frm;
    logic        uf;
    logic        nx;
  } op_t;

  typedef struct packed {
    logic [23:0] mant;
    logic [8:0]  exp;
    logic        g, r, s, zero, sign;
    logic [2:0]  frm;
    logic        uf, nx;
  } res_t;

  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  fmadd_add_normalize_pipe_if bus();
  fmadd_add_normalize_pipe dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

  res_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   mode  = 1;   // 0: out_ready low, 1: high, 2: random
  int   nout  = 0;

  // Reference: find the leading one, shift it up to the hidden-bit position
  // without letting the exponent go below 1.
  function automatic res_t model(op_t o);
    res_t   r;
    int     msb, lz, sh, e;
    longint t;
    logic [26:0] tt;
    r = '0;
    r.sign = o.sign; r.frm = o.frm; r.uf = o.uf; r.nx = o.nx;
    e = int'(o.exp);
    if (o.sum[27]) begin
      r.mant = o.sum[27:4];
      r.g = o.sum[3]; r.r = o.sum[2]; r.s = o.sum[1] | o.sum[0] | o.sticky;
      r.exp = o.exp + 9'd1;
    end else if (o.sum == 28'd0 && !o.sticky) begin
      r.zero = 1'b1;
    end else begin
      msb = -1;
      for (int i = 0; i < 27; i++) if (o.sum[i]) msb = i;
      lz = (msb < 0) ? 27 : 26 - msb;
      sh = (e == 0) ? 0 : ((lz < e - 1) ? lz : e - 1);
      t  = longint'(o.sum[26:0]) << sh;
      tt = t[26:0];
      r.mant = tt[26:3];
      r.g = tt[2]; r.r = tt[1]; r.s = tt[0] | o.sticky;
      r.exp = 9'(e - sh);
    end
    return r;
  endfunction

  function automatic res_t dut_out();
    res_t r;
    r.mant = bus.out_mant;  r.exp = bus.out_exp;
    r.g = bus.out_guard;    r.r = bus.out_round;  r.s = bus.out_sticky;
    r.zero = bus.out_zero;  r.sign = bus.out_sign; r.frm = bus.out_frm;
    r.uf = bus.out_uf_opa;  r.nx = bus.out_nx_mul;
    return r;
  endfunction

  function automatic op_t mk(logic [27:0] s, logic st, logic [8:0] e,
                             logic sg, logic [2:0] f, logic u, logic x);
    op_t o;
    o.sum = s; o.sticky = st; o.exp = e; o.sign = sg; o.frm = f; o.uf = u; o.nx = x;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.sum    = 28'($urandom) >> $urandom_range(0, 28);
    o.sticky = ($urandom_range(0, 3) == 0);
    o.exp    = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 30)) : 9'($urandom_range(0, 510));
    o.sign   = 1'($urandom);
    o.frm    = 3'($urandom_range(0, 4));
    o.uf     = 1'($urandom);
    o.nx     = 1'($urandom);
    return o;
  endfunction

  task automatic check(string name, longint act, longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(op_t o);
    bus.in_valid  = 1'b1;
    bus.in_sum    = o.sum;
    bus.in_sticky = o.sticky;
    bus.in_exp    = o.exp;
    bus.in_sign   = o.sign;
    bus.in_frm    = o.frm;
    bus.in_uf_opa = o.uf;
    bus.in_nx_mul = o.nx;
  endtask

  task automatic send(op_t o);
    int n = 0;
    bit acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      drive(o);
      #2;
      acc = bus.in_ready;
      if (acc) q.push_back(model(o));
      @(posedge clk);
      if (!acc && ++n > 200) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  // Monitor: out_ready generation, ordered scoreboard compare, stall stability.
  initial begin
    bit   stall_prev = 1'b0;
    res_t hold_prev  = '0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
      #2;
      if (rst || flush) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && bus.out_valid) begin
          total++;
          if (dut_out() !== hold_prev) begin
            bad++;
            $display("FAIL hold_stable actual=%h required=%h", dut_out(), hold_prev);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_out actual=%h required=none", dut_out());
          end else begin
            res_t e;
            e = q.pop_front();
            nout++;
            if (dut_out() !== e) begin
              bad++;
              $display("FAIL out%0d actual=%h required=%h", nout, dut_out(), e);
            end
          end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        hold_prev  = dut_out();
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_sticky = 1'b0; bus.in_exp = '0;
    bus.in_sign = 1'b0; bus.in_frm = '0; bus.in_uf_opa = 1'b0; bus.in_nx_mul = 1'b0;
    mode = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready",  bus.in_ready, 1);
    check("rst_out_mant",  bus.out_mant, 0);
    check("rst_out_exp",   bus.out_exp, 0);
    check("rst_out_zero",  bus.out_zero, 0);

    // Directed cases
    send(mk(28'h8000008, 1'b0, 9'd127, 1'b0, 3'b000, 1'b0, 1'b0));
    send(mk(28'h4000000, 1'b1, 9'd100, 1'b1, 3'b001, 1'b1, 1'b0));
    send(mk(28'h0000010, 1'b0, 9'd100, 1'b0, 3'b011, 1'b0, 1'b1));
    send(mk(28'h0000010, 1'b0, 9'd5,   1'b0, 3'b100, 1'b0, 1'b0));
    send(mk(28'h0000000, 1'b0, 9'd77,  1'b1, 3'b010, 1'b0, 1'b0));
    send(mk(28'h0000000, 1'b1, 9'd50,  1'b0, 3'b000, 1'b0, 1'b0));
    send(mk(28'h0000100, 1'b0, 9'd0,   1'b0, 3'b000, 1'b0, 1'b0));
    send(mk(28'h0000003, 1'b1, 9'd1,   1'b1, 3'b001, 1'b1, 1'b1));
    send(mk(28'hFFFFFFF, 1'b0, 9'd509, 1'b0, 3'b000, 1'b0, 1'b0));
    drain();

    // Backpressure: two accepts fill the pipe, third must wait
    mode = 0;
    send(mk(28'h2000001, 1'b0, 9'd40, 1'b0, 3'b000, 1'b0, 1'b0));
    send(mk(28'h9000000, 1'b1, 9'd41, 1'b1, 3'b001, 1'b0, 1'b0));
    @(negedge clk);
    drive(mk(28'h0001234, 1'b0, 9'd42, 1'b0, 3'b010, 1'b1, 1'b0));
    #2;
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    repeat (2) @(posedge clk);
    mode = 1;
    send(mk(28'h0001234, 1'b0, 9'd42, 1'b0, 3'b010, 1'b1, 1'b0));
    send(mk(28'h0000001, 1'b1, 9'd43, 1'b1, 3'b011, 1'b0, 1'b1));
    drain();
    check("bp_count", nout, 13);

    // Flush mid-stall, with a simultaneous offer that must be dropped
    mode = 0;
    send(mk(28'h1234567, 1'b0, 9'd60, 1'b0, 3'b000, 1'b0, 1'b0));
    send(mk(28'h7654321, 1'b0, 9'd61, 1'b0, 3'b000, 1'b0, 1'b0));
    @(negedge clk);
    flush = 1'b1;
    drive(mk(28'h0000555, 1'b0, 9'd62, 1'b0, 3'b000, 1'b0, 1'b0));
    q.delete();
    @(posedge clk);
    #1 flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_out_mant",  bus.out_mant, 0);
    check("flush_in_ready",  bus.in_ready, 1);
    mode = 1;
    repeat (6) @(posedge clk);
    check("flush_no_stale", nout, 13);

    // Reset mid-stall
    mode = 0;
    send(mk(28'h0800000, 1'b1, 9'd70, 1'b1, 3'b000, 1'b0, 1'b0));
    send(mk(28'h0400000, 1'b0, 9'd71, 1'b0, 3'b000, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst2_out_valid", bus.out_valid, 0);
    check("rst2_out_exp",   bus.out_exp, 0);
    check("rst2_in_ready",  bus.in_ready, 1);
    mode = 1;
    repeat (6) @(posedge clk);
    check("rst2_no_stale", nout, 13);

    // Randomized traffic with random backpressure
    mode = 2;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) @(posedge clk);
      send(rnd_op());
    end
    mode = 1;
    drain();
    check("final_count", nout, 413);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
